// File: rtl/debounce_sync.sv
// Input conditioner: synchronises a raw async bit, filters bounces,
// and emits a clean registered level with one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // Clamped copies keep widths legal long enough for the checks below to fire.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1
                    : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(
    (DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NS-1:0] sync_q;
  logic          sync_out;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          dout_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  assign sync_out = sync_q[NS-1];

  // Plain flop chain; only stage 0 may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {NS{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[NS-2:0], din};
    end
  end

  // Count consecutive cycles of disagreement; accept on the last one.
  always_comb begin
    cnt_nxt  = '0;
    dout_nxt = dout;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (sync_out != dout) begin
      if (cnt == CNT_LAST) begin
        dout_nxt = sync_out;
        rise_nxt = sync_out;
        fall_nxt = ~sync_out;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dout <= dout_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default build and a 3-stage/1-cycle build
// driven together, checked by a per-cycle model plus literal edge tables.
module tb_debounce_sync;

  localparam int SA = 2;
  localparam int DA = 4;
  localparam int SB = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b1;
  logic dout_a, rise_a, fall_a;
  logic dout_b, rise_b, fall_b;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA), .RESET_VAL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout_a), .rise(rise_a), .fall(fall_a)
  );

  debounce_sync #(
    .SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB), .RESET_VAL(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout_b), .rise(rise_b), .fall(fall_b)
  );

  // Model: sync_out is din delayed by the stage count; dout takes the
  // new level once sync_out has disagreed for DEBOUNCE_CYCLES edges
  // in a row since the last acceptance.
  int ms[2] = '{SA, SB};
  int md[2] = '{DA, DB};
  bit hist[2][$];
  int streak[2];
  bit m_dout[2];
  bit m_rise[2];
  bit m_fall[2];

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      hist[i].delete();
      for (int k = 0; k < ms[i]; k++) hist[i].push_back(1'b0);
      streak[i] = 0;
      m_dout[i] = 1'b0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
    end
  endtask

  task automatic m_step(input bit d);
    bit so;
    for (int i = 0; i < 2; i++) begin
      if (hist[i].size() == ms[i]) begin
        so = hist[i][ms[i]-1];
        hist[i].push_front(d);
        void'(hist[i].pop_back());
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (so == m_dout[i]) begin
          streak[i] = 0;
        end else begin
          streak[i] = streak[i] + 1;
          if (streak[i] >= md[i]) begin
            m_dout[i] = so;
            m_rise[i] = so;
            m_fall[i] = !so;
            streak[i] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step(din);
  end

  task automatic cmp_model(input string nm, input logic d,
                           input logic r, input logic f, input int i);
    n_cmp++;
    if ({d, r, f} !== {m_dout[i], m_rise[i], m_fall[i]}) begin
      n_err++;
      $display("FAIL model_%s t=%0t: got d/r/f=%b%b%b want %b%b%b",
               nm, $time, d, r, f, m_dout[i], m_rise[i], m_fall[i]);
    end
  endtask

  // Compare both builds with the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_model("a", dout_a, rise_a, fall_a, 0);
      cmp_model("b", dout_b, rise_b, fall_b, 1);
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Literal edge tables, bit e = expected value after edge e.
  bit [7:1] a_up  = 7'b1100000;
  bit [7:1] a_pls = 7'b0100000;
  bit [7:1] b_up  = 7'b1111000;
  bit [7:1] b_pls = 7'b0001000;
  bit [7:1] b_one = 7'b0001000;
  bit [7:1] b_dn  = 7'b0010000;
  bit [5:0] bounce = 6'b110111;
  int nrise;
  int rise_at;

  initial begin
    // Reset asserted mid-cycle with din=1.
    @(posedge clk);
    #3;
    rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_dout_a", dout_a, 1'b0);
    chk("rst_rise_a", rise_a, 1'b0);
    chk("rst_fall_a", fall_a, 1'b0);
    chk("rst_dout_b", dout_b, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hold_a", dout_a, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("rel_dout_a_e%0d", e), dout_a, a_up[e]);
      chk($sformatf("rel_rise_a_e%0d", e), rise_a, a_pls[e]);
      chk($sformatf("rel_dout_b_e%0d", e), dout_b, b_up[e]);
    end

    // Clean rising and falling transitions.
    din = 1'b0;
    repeat (10) tick();
    din = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("up_dout_a_e%0d", e), dout_a, a_up[e]);
      chk($sformatf("up_rise_a_e%0d", e), rise_a, a_pls[e]);
      chk($sformatf("up_fall_a_e%0d", e), fall_a, 1'b0);
      chk($sformatf("up_dout_b_e%0d", e), dout_b, b_up[e]);
      chk($sformatf("up_rise_b_e%0d", e), rise_b, b_pls[e]);
    end
    din = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("dn_dout_a_e%0d", e), dout_a, !a_up[e]);
      chk($sformatf("dn_fall_a_e%0d", e), fall_a, a_pls[e]);
      chk($sformatf("dn_rise_a_e%0d", e), rise_a, 1'b0);
      chk($sformatf("dn_fall_b_e%0d", e), fall_b, b_pls[e]);
    end
    repeat (4) tick();

    // One-cycle din pulse: passes the 1-cycle build, not the default.
    din = 1'b1;
    tick();
    din = 1'b0;
    chk("pls_dout_b_e1", dout_b, b_one[1]);
    for (int e = 2; e <= 7; e++) begin
      tick();
      chk($sformatf("pls_dout_b_e%0d", e), dout_b, b_one[e]);
      chk($sformatf("pls_rise_b_e%0d", e), rise_b, b_one[e]);
      chk($sformatf("pls_fall_b_e%0d", e), fall_b, b_dn[e]);
      chk($sformatf("pls_dout_a_e%0d", e), dout_a, 1'b0);
    end
    repeat (4) tick();

    // Bounce: high 3, low 1, high 2, then low.
    for (int k = 0; k < 16; k++) begin
      din = (k < 6) ? bounce[k] : 1'b0;
      tick();
      chk($sformatf("bnc_dout_a_%0d", k), dout_a, 1'b0);
      chk($sformatf("bnc_rise_a_%0d", k), rise_a, 1'b0);
      chk($sformatf("bnc_fall_a_%0d", k), fall_a, 1'b0);
    end

    // Toggle for 10 cycles, then settle high.
    for (int k = 0; k < 10; k++) begin
      din = (k % 2 == 0);
      tick();
    end
    din = 1'b1;
    nrise = 0;
    rise_at = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (rise_a) begin
        nrise++;
        rise_at = e;
      end
    end
    chk("settle_one_rise", nrise == 1, 1'b1);
    chk("settle_rise_e6", rise_at == 6, 1'b1);
    chk("settle_dout_a", dout_a, 1'b1);

    // Reset between E4 and E5 of a pending rise.
    din = 1'b0;
    repeat (10) tick();
    din = 1'b1;
    repeat (4) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("mid_dout_a", dout_a, 1'b0);
    chk("mid_cnt_a", u_a.cnt == 0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("mid_hold_cnt_a", u_a.cnt == 0, 1'b1);
    chk("mid_hold_dout_a", dout_a, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("mid_dout_a_e%0d", e), dout_a, a_up[e]);
      chk($sformatf("mid_rise_a_e%0d", e), rise_a, a_pls[e]);
    end

    repeat (3) tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
